pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Run-control and hazard sequencer for the 5-stage 16-bit pipeline (IF/ID/EX/MEM/WB).
//  Owns the global run state and detects load-use hazards (stall IF/ID, bubble EX).
//  Detects taken branches resolved in MEM and flushes the younger stages.
//  Provides saturating cycle and stall counters for debug.
// PARAMETERS
//  OP_NOP   5'b00000  NOP opcode (ir[15:11])
//  OP_HALT  5'b00001  HALT opcode
//  OP_LOAD  5'b00010  LOAD opcode; destination is ir[10:8]
//  OP_STORE 5'b00011  STORE opcode; ir[10:8] is a source
//  CNT_W    16        width of cycle_cnt and stall_cnt
// PORTS
//  clock         in   1      system clock, rising edge
//  reset         in   1      asynchronous, active-low
//  enable        in   1      run permission; low pauses the pipeline
//  start         in   1      rising edge launches execution
//  id_ir         in   16     instruction in ID
//  ex_ir         in   16     instruction in EX
//  mem_ir        in   16     instruction in MEM
//  wb_ir         in   16     instruction in WB
//  branch_taken  in   1      flag-evaluated branch condition for mem_ir
//  state         out  1      1 = pipeline advances this cycle
//  stall_if      out  1      hold PC and id_ir
//  bubble_ex     out  1      load NOP into ex_ir instead of id_ir
//  flush         out  1      load NOP into id_ir and ex_ir
//  halted        out  1      HALT has retired
//  cycle_cnt     out  CNT_W  RUN cycles since launch, saturating
//  stall_cnt     out  CNT_W  stall cycles since launch, saturating
// BEHAVIOUR
//  Reset (reset=0, any time, async): FSM=IDLE, start_q=0, all outputs 0, counters 0.
//  start_rise = start & ~start_q. start_q is registered every cycle.
//  FSM states (registered): IDLE, RUN, PAUSE, HALTED.
//   IDLE:   start_rise & enable -> RUN. Clear both counters on this transition.
//   RUN:    wb_ir[15:11]==OP_HALT -> HALTED (takes priority); else ~enable -> PAUSE.
//   PAUSE:  enable -> RUN. start is ignored.
//   HALTED: start_rise & enable -> RUN. Clear counters and halted.
//  state = (FSM==RUN). It is registered, so it goes high 1 cycle after the launching edge.
//  halted = (FSM==HALTED). It is registered.
//  Outputs stall_if, bubble_ex and flush are combinational from FSM and stage IRs, same cycle.
//   All three are 0 outside RUN.
//  Load-use hazard (hz):
//   ex_ir[15:11]==OP_LOAD and id_ir[15:11] not in {OP_NOP, OP_HALT}.
//   The ID instruction must also read d = ex_ir[10:8]:
//    id_ir[6:4]==d, or id_ir[2:0]==d,
//    or (id_ir[15:11]==OP_STORE or id_ir[15:14]==2'b11) and id_ir[10:8]==d.
//   This check is conservative: it matches fields whether or not they are used.
//  Branch flush (fl): mem_ir[15:14]==2'b11 & branch_taken.
//  In RUN:
//   flush = fl.
//   stall_if = bubble_ex = hz & ~fl. Flush wins because it already clears EX.
//  A stall lasts exactly 1 cycle: the LOAD moves to MEM, so hz drops.
//  cycle_cnt +1 per RUN cycle. stall_cnt +1 per cycle with stall_if=1.
//  Both counters saturate at all-ones and hold in PAUSE/HALTED/IDLE.
//  Reset mid-RUN: immediate IDLE. The pipeline must be re-launched with start.
// TESTING
//  T1 launch: reset release; start 0->1, enable=1
//     -> state=1 on 2nd edge; cycle_cnt=0 then 1,2,...
//  T2 load-use: ex_ir=LOAD r3, id_ir=ADD r1,r3,r2 (id[6:4]=3)
//     -> stall_if=bubble_ex=1 for 1 cycle, stall_cnt=1.
//     Same with id_ir reading r4 -> no stall.
//  T3 flush priority: mem_ir=16'hD000 (BZ), branch_taken=1, plus T2 hazard
//     -> flush=1, stall_if=0, bubble_ex=0.
//     branch_taken=0 -> flush=0.
//  T4 halt: wb_ir[15:11]=OP_HALT while enable=1
//     -> next edge state=0, halted=1, counters frozen.
//     New start edge -> RUN, halted=0, counters cleared.
//  T5 pause: enable=0 for 3 cycles in RUN
//     -> state=0, no stall/flush, cycle_cnt unchanged.
//     enable=1 -> RUN, counting resumes.
//  T6 async reset mid-stall: reset=0 between edges
//     -> all outputs 0 immediately, FSM=IDLE. Saturation: preset
//     cycle_cnt=16'hFFFE, run 3 cycles -> holds 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Run-control and hazard sequencer for a 5-stage 16-bit pipeline.
// Owns the run state, load-use stall/bubble, branch flush and debug counters.
module pipe_hazard_ctrl #(
   parameter logic [4:0]  OP_NOP   = 5'b00000,
   parameter logic [4:0]  OP_HALT  = 5'b00001,
   parameter logic [4:0]  OP_LOAD  = 5'b00010,
   parameter logic [4:0]  OP_STORE = 5'b00011,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic [15:0]      id_ir,
   input  logic [15:0]      ex_ir,
   input  logic [15:0]      mem_ir,
   input  logic [15:0]      wb_ir,
   input  logic             branch_taken,
   output logic             state,
   output logic             stall_if,
   output logic             bubble_ex,
   output logic             flush,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      PAUSE  = 2'b10,
      HALTED = 2'b11
   } fsm_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   fsm_t             fsm_r;
   fsm_t             fsm_nxt_s;
   logic             start_q_r;
   logic             start_rise_s;
   logic             clr_cnt_s;
   logic             run_s;
   logic             hz_s;
   logic             fl_s;
   logic             state_r;
   logic             halted_r;
   logic [CNT_W-1:0] cycle_cnt_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic             unused_bits_s;

   // Conservative source-register match: a field counts even if the opcode ignores it.
   function automatic logic reads_reg(input logic [15:0] ir, input logic [2:0] d,
                                      input logic [4:0] op_store);
      logic dst_is_src;
      dst_is_src = (ir[15:11] == op_store) || (ir[15:14] == 2'b11);
      return (ir[6:4] == d) || (ir[2:0] == d) || (dst_is_src && (ir[10:8] == d));
   endfunction

   assign start_rise_s  = start & ~start_q_r;
   assign run_s         = (fsm_r == RUN);
   assign unused_bits_s = ^{ex_ir[7:0], mem_ir[13:0], wb_ir[10:0], id_ir[7], id_ir[3]};

   // Next-state decode; launching from IDLE or HALTED also clears the counters.
   always_comb begin
      fsm_nxt_s = fsm_r;
      clr_cnt_s = 1'b0;
      case (fsm_r)
         IDLE, HALTED: begin
            if (start_rise_s && enable) begin
               fsm_nxt_s = RUN;
               clr_cnt_s = 1'b1;
            end else begin
               fsm_nxt_s = fsm_r;
            end
         end
         RUN: begin
            if (wb_ir[15:11] == OP_HALT) begin
               fsm_nxt_s = HALTED;
            end else if (!enable) begin
               fsm_nxt_s = PAUSE;
            end else begin
               fsm_nxt_s = RUN;
            end
         end
         PAUSE: begin
            if (enable) begin
               fsm_nxt_s = RUN;
            end else begin
               fsm_nxt_s = PAUSE;
            end
         end
         default: begin
            fsm_nxt_s = IDLE;
         end
      endcase
   end

   // Hazard and flush detection; flush wins because it already clears EX.
   always_comb begin
      hz_s = 1'b0;
      if ((ex_ir[15:11] == OP_LOAD) && (id_ir[15:11] != OP_NOP) && (id_ir[15:11] != OP_HALT)) begin
         hz_s = reads_reg(id_ir, ex_ir[10:8], OP_STORE);
      end else begin
         hz_s = 1'b0;
      end
      fl_s      = (mem_ir[15:14] == 2'b11) && branch_taken;
      flush     = run_s & fl_s;
      stall_if  = run_s & hz_s & ~fl_s;
      bubble_ex = run_s & hz_s & ~fl_s;
   end

   // FSM, start edge detector and decoded state flags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fsm_r     <= IDLE;
         start_q_r <= 1'b0;
         state_r   <= 1'b0;
         halted_r  <= 1'b0;
      end else begin
         fsm_r     <= fsm_nxt_s;
         start_q_r <= start;
         state_r   <= (fsm_nxt_s == RUN);
         halted_r  <= (fsm_nxt_s == HALTED);
      end
   end

   // Saturating debug counters; only RUN cycles can advance them.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cycle_cnt_r <= {CNT_W{1'b0}};
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (clr_cnt_s) begin
         cycle_cnt_r <= {CNT_W{1'b0}};
         stall_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (run_s && (cycle_cnt_r != CNT_MAX)) begin
            cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
         end
         if (stall_if && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
         end
      end
   end

   assign state     = state_r;
   assign halted    = halted_r;
   assign cycle_cnt = cycle_cnt_r;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazard/flush vector table plus
// launch, pause, halt, async reset and counter saturation sequences.
module tb_pipe_hazard_ctrl;

   logic        clock;
   logic        reset;
   logic        enable;
   logic        start;
   logic [15:0] id_ir;
   logic [15:0] ex_ir;
   logic [15:0] mem_ir;
   logic [15:0] wb_ir;
   logic        branch_taken;
   logic        state;
   logic        stall_if;
   logic        bubble_ex;
   logic        flush;
   logic        halted;
   logic [15:0] cycle_cnt;
   logic [15:0] stall_cnt;

   int n_chk;
   int n_fail;
   int exp_cyc;
   int exp_stl;

   typedef struct {
      logic [15:0] id;
      logic [15:0] ex;
      logic [15:0] mem;
      logic        bt;
      logic        e_stall;
      logic        e_flush;
   } vec_t;

   vec_t vecs[14];

   pipe_hazard_ctrl dut (
      .clock(clock), .reset(reset), .enable(enable), .start(start),
      .id_ir(id_ir), .ex_ir(ex_ir), .mem_ir(mem_ir), .wb_ir(wb_ir),
      .branch_taken(branch_taken), .state(state), .stall_if(stall_if),
      .bubble_ex(bubble_ex), .flush(flush), .halted(halted),
      .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_irs(input logic [15:0] id, input logic [15:0] ex,
                          input logic [15:0] mem, input logic bt);
      id_ir        = id;
      ex_ir        = ex;
      mem_ir       = mem;
      branch_taken = bt;
   endtask

   initial begin
      n_chk = 0; n_fail = 0; exp_cyc = 0; exp_stl = 0;
      clock = 1'b0; reset = 1'b0; enable = 1'b0; start = 1'b0;
      wb_ir = 16'h0000;
      set_irs(16'h2132, 16'h1300, 16'hD000, 1'b1);

      //                id        ex        mem       bt    stall flush
      vecs[0]  = '{16'h2132, 16'h1300, 16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{16'h2142, 16'h1300, 16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{16'h2143, 16'h1300, 16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{16'h1B00, 16'h1300, 16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{16'h2300, 16'h1300, 16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{16'hD300, 16'h1300, 16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{16'h0030, 16'h1300, 16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{16'h0830, 16'h1300, 16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{16'h2132, 16'h2300, 16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{16'h2100, 16'h1000, 16'h0000, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{16'h2132, 16'h1300, 16'hD000, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{16'h2132, 16'h1300, 16'hD000, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{16'h2132, 16'h1300, 16'h9000, 1'b1, 1'b1, 1'b0};
      vecs[13] = '{16'h0000, 16'h0000, 16'hC000, 1'b1, 1'b0, 1'b1};

      // Reset state, with hazard and flush patterns present on the IRs
      tick(); tick(); #1;
      chk1("rst_state", state, 1'b0);
      chk1("rst_halted", halted, 1'b0);
      chk1("rst_stall", stall_if, 1'b0);
      chk1("rst_flush", flush, 1'b0);
      chk16("rst_cyc", cycle_cnt, 16'h0000);
      chk16("rst_stl", stall_cnt, 16'h0000);

      // Launch
      reset = 1'b1;
      set_irs(16'h0000, 16'h0000, 16'h0000, 1'b0);
      tick();
      enable = 1'b1; start = 1'b1;
      tick();
      chk1("launch_state", state, 1'b1);
      chk16("launch_cyc0", cycle_cnt, 16'h0000);
      tick(); exp_cyc = 1;
      chk16("launch_cyc1", cycle_cnt, 16'(exp_cyc));
      tick(); exp_cyc = 2;
      chk16("launch_cyc2", cycle_cnt, 16'(exp_cyc));

      // Hazard/flush vector table, one RUN cycle per vector
      for (int i = 0; i < 14; i++) begin
         set_irs(vecs[i].id, vecs[i].ex, vecs[i].mem, vecs[i].bt);
         #1;
         chk1($sformatf("vec%0d_stall_if", i), stall_if, vecs[i].e_stall);
         chk1($sformatf("vec%0d_bubble_ex", i), bubble_ex, vecs[i].e_stall);
         chk1($sformatf("vec%0d_flush", i), flush, vecs[i].e_flush);
         tick();
         exp_cyc++;
         exp_stl += int'(vecs[i].e_stall);
         if (i == 0) chk16("first_stall_cnt", stall_cnt, 16'h0001);
      end
      chk16("table_stl", stall_cnt, 16'(exp_stl));
      chk16("table_cyc", cycle_cnt, 16'(exp_cyc));

      // Pause for 3 cycles
      set_irs(16'h0000, 16'h0000, 16'h0000, 1'b0);
      enable = 1'b0;
      tick(); exp_cyc++;
      chk1("pause_state", state, 1'b0);
      set_irs(16'h2132, 16'h1300, 16'hD000, 1'b1);
      #1;
      chk1("pause_stall", stall_if, 1'b0);
      chk1("pause_flush", flush, 1'b0);
      tick(); tick(); tick();
      chk16("pause_cyc", cycle_cnt, 16'(exp_cyc));
      chk16("pause_stl", stall_cnt, 16'(exp_stl));
      set_irs(16'h0000, 16'h0000, 16'h0000, 1'b0);
      enable = 1'b1;
      tick();
      chk1("resume_state", state, 1'b1);
      chk16("resume_cyc", cycle_cnt, 16'(exp_cyc));
      tick(); exp_cyc++;
      chk16("resume_cyc_inc", cycle_cnt, 16'(exp_cyc));

      // Halt takes priority over enable low
      wb_ir = 16'h0800; enable = 1'b0;
      tick(); exp_cyc++;
      chk1("halt_state", state, 1'b0);
      chk1("halt_halted", halted, 1'b1);
      chk16("halt_cyc", cycle_cnt, 16'(exp_cyc));
      wb_ir = 16'h0000; enable = 1'b1;
      tick(); tick();
      chk1("halt_hold_state", state, 1'b0);
      chk1("halt_hold_halted", halted, 1'b1);
      chk16("halt_frozen_cyc", cycle_cnt, 16'(exp_cyc));
      start = 1'b0;
      tick();
      start = 1'b1;
      tick(); exp_cyc = 0;
      chk1("relaunch_state", state, 1'b1);
      chk1("relaunch_halted", halted, 1'b0);
      chk16("relaunch_cyc", cycle_cnt, 16'h0000);
      chk16("relaunch_stl", stall_cnt, 16'h0000);
      tick(); exp_cyc = 1;
      chk16("relaunch_cyc1", cycle_cnt, 16'(exp_cyc));

      // Async reset between edges while stalling
      set_irs(16'h2132, 16'h1300, 16'h0000, 1'b0);
      #1;
      chk1("pre_reset_stall", stall_if, 1'b1);
      #1 reset = 1'b0;
      #1;
      chk1("areset_stall", stall_if, 1'b0);
      chk1("areset_bubble", bubble_ex, 1'b0);
      chk1("areset_state", state, 1'b0);
      chk16("areset_cyc", cycle_cnt, 16'h0000);
      chk16("areset_stl", stall_cnt, 16'h0000);
      start = 1'b0;
      #1 reset = 1'b1;
      tick(); tick();
      chk1("post_reset_idle", state, 1'b0);
      chk1("post_reset_stall", stall_if, 1'b0);

      // Saturation of cycle_cnt
      set_irs(16'h0000, 16'h0000, 16'h0000, 1'b0);
      start = 1'b1;
      tick();
      chk16("sat_launch", cycle_cnt, 16'h0000);
      repeat (65534) @(posedge clock);
      #1;
      chk16("sat_fffe", cycle_cnt, 16'hFFFE);
      tick(); tick(); tick();
      chk16("sat_ffff", cycle_cnt, 16'hFFFF);
      chk1("sat_state", state, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
